// File: rtl/ps2_key_event_if.sv
// rtl/ps2_key_event_if.sv - scan-code input and key-event output handshake bundle
//
// Groups the byte strobe coming from the PS/2 frame receiver and the
// valid/ready key-event stream going to the ASCII/display stage.
//   code_valid, code : one-cycle strobe plus scan-code byte (master -> slave)
//   ev_valid         : head event presented (slave -> master)
//   ev_ready         : consumer accepts the head event (master -> slave)
//   ev_code/ev_ext/ev_brk : head event fields (slave -> master)
// The decoder instantiates the slave modport; the driving side uses master.
interface ps2_key_event_if;
  logic       code_valid;
  logic [7:0] code;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (
    output code_valid,
    output code,
    output ev_ready,
    input  ev_valid,
    input  ev_code,
    input  ev_ext,
    input  ev_brk
  );

  modport slave (
    input  code_valid,
    input  code,
    input  ev_ready,
    output ev_valid,
    output ev_code,
    output ev_ext,
    output ev_brk
  );
endinterface

// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - PS/2 set-2 prefix decoder, key-event FIFO and make counter
//
// Turns E0/F0-prefixed scan-code byte sequences into single key events
// {code, ext, brk}, buffers them in a DEPTH-entry FIFO and counts accepted
// make events.
//   clk       : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   bus       : ps2_key_event_if.slave (byte strobe in, event stream out)
//   key_count : accepted make events, wraps 255 -> 0
//   overflow  : sticky, an event was dropped because the FIFO was full
//   ovf_clr   : synchronous clear of overflow (a same-cycle drop wins)
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppresses typematic repeats
// of the most recently pressed key.
module ps2_key_event #(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  ps2_key_event_if.slave        bus,
  output logic [7:0]            key_count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_E0   = 2'd1,
    PRE_F0   = 2'd2,
    PRE_E0F0 = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  logic [7:0] emit_code;

  // Bytes that the keyboard sends outside of key sequences (self-test pass,
  // ack, resend, pause prefix). Only dropped when no prefix is pending.
  function automatic logic is_noise(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hE1);
  endfunction

  // ---------------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    emit_code = bus.code;
    if (bus.code_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.code == 8'hE0) begin
            state_d = PRE_E0;
          end else if (bus.code == 8'hF0) begin
            state_d = PRE_F0;
          end else if (!is_noise(bus.code)) begin
            emit = 1'b1;
          end
        end
        PRE_E0: begin
          if (bus.code == 8'hF0) begin
            state_d = PRE_E0F0;
          end else if (bus.code != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        PRE_F0: begin
          if (bus.code == 8'hE0) begin
            state_d = PRE_E0F0;
          end else if (bus.code != 8'hF0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        PRE_E0F0: begin
          if ((bus.code != 8'hE0) && (bus.code != 8'hF0)) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Typematic repeat filter
  // ---------------------------------------------------------------------------
  logic suppress;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_q, held_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d;
  logic       held_match;

  assign held_match = held_q && (emit_code == held_code_q) && (emit_ext == held_ext_q);

  always_comb begin
    suppress    = emit && !emit_brk && held_match;
    held_d      = held_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    if (emit && !emit_brk && !held_match) begin
      held_d      = 1'b1;
      held_code_d = emit_code;
      held_ext_d  = emit_ext;
    end else if (emit && emit_brk && held_match) begin
      held_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held_q      <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
    end else begin
      held_q      <= held_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
    end
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Event FIFO: entries are {ext, brk, code}
  // ---------------------------------------------------------------------------
  logic [9:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  logic        empty;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        drop;
  logic [9:0]  head;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_req = emit && !suppress;
  assign pop      = !empty && bus.ev_ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is reset so the head fields read zero while empty after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {emit_ext, emit_brk, emit_code};
    end
  end

  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.ev_valid = !empty;
  assign bus.ev_ext   = head[9];
  assign bus.ev_brk   = head[8];
  assign bus.ev_code  = head[7:0];

  // ---------------------------------------------------------------------------
  // Make counter and sticky overflow
  // ---------------------------------------------------------------------------
  logic [7:0] key_count_q, key_count_d;
  logic       overflow_q, overflow_d;

  always_comb begin
    key_count_d = key_count_q;
    if (push_ok && !emit_brk) begin
      key_count_d = key_count_q + 8'd1;
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_count_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      key_count_q <= key_count_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_count = key_count_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Sits directly downstream of the PS/2 frame receiver; consumes its validated, parity-checked scan-code bytes.
- Decodes PS/2 set-2 prefixes (E0 extended, F0 break) into single key events {code, ext, brk}.
- Buffers events in a small FIFO with a valid/ready output for the ASCII/display stage.
- Maintains a make-event counter for the seven-segment key counter.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >=2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- code_valid  in  1  one-cycle strobe, byte from frame receiver is valid
- code  in  8  received scan-code byte
- ev_valid  out  1  FIFO non-empty, head event presented
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_code  out  8  head event scan code (prefixes stripped)
- ev_ext  out  1  head event had E0 prefix
- ev_brk  out  1  head event is a release (F0 prefix)
- key_count  out  8  accepted make events, wraps 255->0
- overflow  out  1  sticky: event dropped because FIFO full
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, resetn=0): decoder in IDLE, FIFO empty, ev_valid=0, key_count=0, overflow=0, held=0. ev_code/ev_ext/ev_brk read 0 while empty after reset. Reset mid-sequence discards any partial prefix and all buffered events.
- Decoder FSM acts only on cycles with code_valid=1:
  - IDLE: E0->PRE_E0; F0->PRE_F0; AA/FA/FE/E1 discarded, stay IDLE; else emit {code,ext=0,brk=0}, IDLE.
  - PRE_E0: F0->PRE_E0F0; E0->PRE_E0; else emit {code,1,0}, IDLE.
  - PRE_F0: E0->PRE_E0F0; F0->PRE_F0; else emit {code,0,1}, IDLE.
  - PRE_E0F0: E0/F0 stay; else emit {code,1,1}, IDLE.
  - In PRE_* states AA/FA/FE/E1 are emitted as ordinary codes (no discard).
- Emit = push request in the same cycle as code_valid. Event is visible at FIFO head (ev_valid=1 if previously empty) on the next cycle: latency 1.
- FIFO:
  - Register array, wr_ptr/rd_ptr of AW+1 bits. Full when pointer MSBs differ and low bits equal; empty when pointers are equal.
  - Head fields are combinational from array[rd_ptr].
  - Pop on ev_valid & ev_ready; ev_ready while empty has no effect.
  - Push accepted if not full, or full with a pop in the same cycle.
  - Push refused when full without a pop: event dropped, overflow<=1, key_count unchanged.
  - Push and pop together while empty: push accepted, nothing popped; ev_valid=1 next cycle (no bypass).
  - Pointers wrap modulo 2*DEPTH.
- key_count increments by 1 per accepted (pushed) make event; break events are not counted. 8-bit wrap, no saturation.
- overflow: set on drop, cleared by ovf_clr. Drop and ovf_clr in the same cycle: set wins.
- code_valid is assumed never asserted on consecutive cycles less than 1 apart; back-to-back strobes are each processed.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Holds one register {held, held_code, held_ext}.
  - A make matching held_code/held_ext while held=1 is a typematic repeat: suppressed, not pushed, not counted.
  - Any other make is pushed and counted, and loads held_code/held_ext with held=1.
  - A break matching held_code/held_ext clears held; the break itself is always pushed.
  - Reset clears held.
- Undefined: every make is pushed and counted; the held register is absent.

Test Plan:
- Byte 1C -> one cycle later ev_valid=1, ev_code=1C, ext=0, brk=0; key_count=1.
- Bytes F0,1C -> single event {1C,0,1}; key_count unchanged.
- Bytes E0,F0,75 and E0,75 -> events {75,1,1} then {75,1,0} in order.
- ev_ready=0, 9 makes with DEPTH=8 -> 8 entries buffered, overflow=1, key_count=8. Then ovf_clr -> overflow=0. Then drain -> codes in push order, ev_valid drops after the 8th pop.
- Full FIFO with push and pop in the same cycle -> push accepted, count stays 8, overflow stays 0. Assert resetn low mid-prefix (after E0) -> ev_valid=0, key_count=0; next byte 1C decodes as {1C,0,0}.
- With PS2_TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C,1C -> events {1C,0,0},{1C,0,1},{1C,0,0}; key_count=2. Without the macro: 5 events, key_count=4.
